sprite_scan: RTL and testbench

SPRITE_SCAN -- requirements
Module: sprite_scan

---
 rtl/sprite_defines_pkg.sv | 27 ++
 rtl/sprite_row_hit.sv | 18 +
 rtl/sprite_scan.sv | 124 ++++++++++++
 tb/tb_sprite_scan.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_defines_pkg.sv
// rtl/sprite_defines_pkg.sv - shared sprite types, defaults and scan FSM states
package sprite_defines;

    localparam int DEF_MAX_HITS    = 16;
    localparam int DEF_NUM_SPRITES = 128;

    typedef struct packed {
        logic       enable;
        logic [1:0] size;
        logic [7:0] y;
        logic [7:0] x;
        logic [7:0] tile;
    } sprite_conf_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    // Sprite heights are 8, 16, 32 or 64 rows.
    function automatic logic [7:0] sprite_height(input logic [1:0] size);
        return 8'd8 << size;
    endfunction

endpackage

// File: rtl/sprite_row_hit.sv
// rtl/sprite_row_hit.sv - combinational test of whether a sprite covers a scanline
module sprite_row_hit
    import sprite_defines::*;
(
    input  logic [7:0] row,
    input  logic [7:0] y,
    input  logic [1:0] size,
    input  logic       enable,
    output logic       hit
);

    logic [7:0] w_diff;

    // Modulo-256 difference lets sprites straddling row 255 wrap onto row 0.
    assign w_diff = row - y;
    assign hit    = enable && (w_diff < sprite_height(size));

endmodule

// File: rtl/sprite_scan.sv
// rtl/sprite_scan.sv - per-scanline OAM scan building the line sprite list
module sprite_scan
    import sprite_defines::*;
#(
    parameter int MAX_HITS    = DEF_MAX_HITS,
    parameter int NUM_SPRITES = DEF_NUM_SPRITES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          scan_start,
    input  logic [7:0]                    scan_row,
    output logic [$clog2(NUM_SPRITES)-1:0] oam_addr,
    output logic                          oam_read,
    input  logic                          oam_avail,
    input  sprite_conf_t                  oam_data,
    output logic                          hit_we,
    output logic [$clog2(MAX_HITS)-1:0]   hit_slot,
    output sprite_conf_t                  hit_data,
    output logic                          scan_busy,
    output logic                          scan_done,
    output logic [$clog2(MAX_HITS):0]     hit_count,
    output logic                          overflow
);

    localparam int AW = $clog2(NUM_SPRITES);
    localparam int SW = $clog2(MAX_HITS);
    localparam int CW = SW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_SPRITES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_HITS);

    scan_state_t   r_state;
    logic [7:0]    r_row;
    logic [AW-1:0] r_addr;
    logic          r_read;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_hit;
    logic w_process;
    logic w_room;
    logic w_we;
    logic w_ovf_hit;

    sprite_row_hit u_row_hit (
        .row    (r_row),
        .y      (oam_data.y),
        .size   (oam_data.size),
        .enable (oam_data.enable),
        .hit    (w_hit)
    );

    // Read data is only meaningful while a read can still be in flight.
    assign w_process = oam_avail && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_room    = (r_count < FULL_CNT);
    assign w_we      = w_process && w_hit && w_room;
    assign w_ovf_hit = w_process && w_hit && !w_room;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_we) begin
                r_count <= r_count + CW'(1);
            end
            if (w_ovf_hit) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (scan_start) begin
                        r_row   <= scan_row;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_addr  <= '0;
                        r_read  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Stop on the first hit that finds the list full; one read stays in flight.
                    if (w_ovf_hit || (r_addr == LAST_ADDR)) begin
                        r_read  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oam_addr  = r_addr;
    assign oam_read  = r_read;
    assign hit_we    = w_we;
    assign hit_slot  = r_count[SW-1:0];
    assign hit_data  = w_we ? oam_data : '0;
    assign scan_busy = r_busy;
    assign scan_done = r_done;
    assign hit_count = r_count;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_sprite_scan.sv
// tb/tb_sprite_scan.sv - directed self-checking bench for sprite_scan
module tb_sprite_scan;
    import sprite_defines::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         scan_start;
    logic [7:0]   scan_row;
    logic [6:0]   oam_addr;
    logic         oam_read;
    logic         oam_avail = 1'b0;
    sprite_conf_t oam_data = '0;
    logic         hit_we;
    logic [3:0]   hit_slot;
    sprite_conf_t hit_data;
    logic         scan_busy;
    logic         scan_done;
    logic [4:0]   hit_count;
    logic         overflow;

    sprite_scan dut (
        .clock      (clock),
        .reset      (reset),
        .scan_start (scan_start),
        .scan_row   (scan_row),
        .oam_addr   (oam_addr),
        .oam_read   (oam_read),
        .oam_avail  (oam_avail),
        .oam_data   (oam_data),
        .hit_we     (hit_we),
        .hit_slot   (hit_slot),
        .hit_data   (hit_data),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .hit_count  (hit_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    sprite_conf_t mem [128];
    int cyc = 0;

    always @(posedge clock) begin
        cyc       <= cyc + 1;
        oam_avail <= oam_read;
        oam_data  <= mem[oam_addr];
    end

    logic [7:0] slot_q [$];
    logic [7:0] x_q    [$];
    int n_done = 0;
    int done_cyc = 0;
    int n_reads = 0;
    int first_read_cyc = 0;
    int last_read_cyc = 0;
    int last_read_addr = 0;
    int busy_rise_cyc = 0;
    logic prev_busy = 1'b0;

    always @(negedge clock) begin
        if (hit_we === 1'b1) begin
            slot_q.push_back({4'd0, hit_slot});
            x_q.push_back(hit_data.x);
        end
        if (scan_done === 1'b1) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (oam_read === 1'b1) begin
            n_reads        = n_reads + 1;
            last_read_cyc  = cyc;
            last_read_addr = int'(oam_addr);
            if (oam_addr == 7'd0) first_read_cyc = cyc;
        end
        if ((scan_busy === 1'b1) && !prev_busy) busy_rise_cyc = cyc;
        prev_busy = (scan_busy === 1'b1);
    end

    int n_checks = 0;
    int n_errors = 0;
    int t0, h0, d0, r0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = '{enable: 1'b0, size: 2'd0, y: 8'd0, x: 8'(i), tile: 8'd0};
    endtask

    task automatic set_sprite(input int idx, input logic [7:0] y, input logic [1:0] size, input logic en);
        mem[idx] = '{enable: en, size: size, y: y, x: 8'(idx), tile: 8'(idx)};
    endtask

    task automatic start_scan(input logic [7:0] row);
        @(negedge clock);
        scan_row   = row;
        scan_start = 1'b1;
        t0 = cyc;
        h0 = slot_q.size();
        d0 = n_done;
        r0 = n_reads;
        @(negedge clock);
        scan_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            #1;
            if (n_done != d0) break;
        end
        check({tag, "_done_seen"}, n_done - d0, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"},  oam_read, 0);
        check({tag, "_addr"},  oam_addr, 0);
        check({tag, "_we"},    hit_we, 0);
        check({tag, "_slot"},  hit_slot, 0);
        check({tag, "_data"},  hit_data, 0);
        check({tag, "_busy"},  scan_busy, 0);
        check({tag, "_done"},  scan_done, 0);
        check({tag, "_count"}, hit_count, 0);
        check({tag, "_ovf"},   overflow, 0);
    endtask

    initial begin
        reset      = 1'b1;
        scan_start = 1'b0;
        scan_row   = 8'd0;
        clear_mem();
        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        reset = 1'b0;

        // No sprites enabled.
        start_scan(8'd10);
        wait_done("empty");
        check("empty_hits", slot_q.size() - h0, 0);
        check("empty_done_cyc", done_cyc - t0, 130);
        check("empty_count", hit_count, 0);
        check("empty_ovf", overflow, 0);
        check("empty_reads", n_reads - r0, 128);
        check("empty_first_read", first_read_cyc - t0, 1);
        check("empty_last_read", last_read_cyc - t0, 128);
        check("empty_busy_rise", busy_rise_cyc - t0, 1);
        check("empty_busy_end", scan_busy, 0);

        // Three hits spread across the table.
        set_sprite(3, 8'd5, 2'd0, 1'b1);
        set_sprite(70, 8'd5, 2'd0, 1'b1);
        set_sprite(127, 8'd5, 2'd0, 1'b1);
        start_scan(8'd12);
        wait_done("three");
        check("three_hits", slot_q.size() - h0, 3);
        for (int i = 0; i < 3; i++) begin
            int exp_x [3] = '{3, 70, 127};
            check($sformatf("three_slot%0d", i), slot_q[h0 + i], i);
            check($sformatf("three_x%0d", i), x_q[h0 + i], exp_x[i]);
        end
        check("three_count", hit_count, 3);
        check("three_done_cyc", done_cyc - t0, 130);

        // Wrap boundary; a disabled twin never hits.
        clear_mem();
        set_sprite(50, 8'd250, 2'd1, 1'b1);
        set_sprite(51, 8'd250, 2'd1, 1'b0);
        start_scan(8'd9);
        wait_done("wrap9");
        check("wrap9_hits", slot_q.size() - h0, 1);
        check("wrap9_x", x_q[h0], 50);
        start_scan(8'd10);
        wait_done("wrap10");
        check("wrap10_hits", slot_q.size() - h0, 0);
        check("wrap10_count", hit_count, 0);

        // Overflow: 20 sprites on one row.
        clear_mem();
        for (int i = 0; i < 20; i++) set_sprite(i, 8'd40, 2'd0, 1'b1);
        start_scan(8'd40);
        wait_done("ovf");
        check("ovf_hits", slot_q.size() - h0, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_slot%0d", i), slot_q[h0 + i], i);
            check($sformatf("ovf_x%0d", i), x_q[h0 + i], i);
        end
        check("ovf_flag", overflow, 1);
        check("ovf_count", hit_count, 16);
        check("ovf_last_addr", last_read_addr, 17);
        check("ovf_reads", n_reads - r0, 18);
        check("ovf_done_cyc", done_cyc - t0, 20);

        // Second scan_start during a scan is ignored.
        clear_mem();
        start_scan(8'd10);
        repeat (49) @(negedge clock);
        scan_row   = 8'd99;
        scan_start = 1'b1;
        @(negedge clock);
        scan_start = 1'b0;
        wait_done("busy");
        check("busy_done_cyc", done_cyc - t0, 130);
        repeat (200) @(negedge clock);
        check("busy_single_done", n_done - d0, 1);
        check("busy_idle", scan_busy, 0);
        check("busy_ovf_cleared", overflow, 0);

        // Reset mid-scan while sprite 59's read is in flight.
        set_sprite(59, 8'd30, 2'd0, 1'b1);
        start_scan(8'd30);
        repeat (59) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (200) @(negedge clock);
        check("midrst_no_hits", slot_q.size() - h0, 0);
        check("midrst_no_done", n_done - d0, 0);
        start_scan(8'd30);
        wait_done("after");
        check("after_hits", slot_q.size() - h0, 1);
        check("after_x", x_q[h0], 59);
        check("after_done_cyc", done_cyc - t0, 130);
        check("after_count", hit_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
